fma_operand_unpack: RTL and testbench

- Front-end of the single-precision FMA datapath, computing A + B*C.
- Accepts three packed IEEE-754 binary32 operands and splits them into sign, exponent and mantissa fields.
- Classifies each operand as zero, denormal, infinity, qNaN or sNaN, and detects invalid operations early.
- Computes the product exponent and the addend alignment shift. Fields and flags are handed to the multiplier/aligner and, after the adder, to the normalize-and-round stage.
- Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/fma_operand_unpack.sv | 228 ++++++++++++++++++++++
 tb/tb_fma_operand_unpack.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_operand_unpack.sv
// fma_operand_unpack: splits A, B, C (A + B*C) into fields, classifies them, computes product exponent and addend shift.
// Latency: 2 cycles (decode register, compute register); one operand triple per cycle when Ready_i stays high.
// Backpressure: Ready_o drops only when both stages hold data and Ready_i is low; Ready_o never depends on Valid_i.
// Ports: clk_i/rst_ni (sync active-low); Valid_i/Ready_o + A_i/B_i/C_i/Sub_i/Rounding_mode_i in;
//        Valid_o/Ready_i + signs, effective A exponent, mantissas with hidden bit, Exp_bc_o, Exp_o,
//        Align_shift_o, A_dominant_o, Sub_Sign_o, class flags, Invalid_o, Rounding_mode_o out.
module fma_operand_unpack #(
  parameter int PARM_EXP       = 8,
  parameter int PARM_MANT      = 23,
  parameter int PARM_RM        = 3,
  parameter int PARM_BIAS      = 127,
  parameter int PARM_SHIFT_MAX = 74
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          Valid_i,
  output logic                          Ready_o,
  input  logic [PARM_EXP+PARM_MANT:0]   A_i,
  input  logic [PARM_EXP+PARM_MANT:0]   B_i,
  input  logic [PARM_EXP+PARM_MANT:0]   C_i,
  input  logic                          Sub_i,
  input  logic [PARM_RM-1:0]            Rounding_mode_i,
  output logic                          Valid_o,
  input  logic                          Ready_i,
  output logic                          A_Sign_o,
  output logic                          B_Sign_o,
  output logic                          C_Sign_o,
  output logic [PARM_EXP-1:0]           A_Exp_raw_o,
  output logic [PARM_MANT:0]            A_Mant_o,
  output logic [PARM_MANT:0]            B_Mant_o,
  output logic [PARM_MANT:0]            C_Mant_o,
  output logic [PARM_EXP+1:0]           Exp_bc_o,
  output logic [PARM_EXP+1:0]           Exp_o,
  output logic [6:0]                    Align_shift_o,
  output logic                          A_dominant_o,
  output logic                          Sub_Sign_o,
  output logic                          A_DeN_o,
  output logic                          A_Inf_o,
  output logic                          B_Inf_o,
  output logic                          C_Inf_o,
  output logic                          A_Zero_o,
  output logic                          B_Zero_o,
  output logic                          C_Zero_o,
  output logic                          A_NaN_o,
  output logic                          B_NaN_o,
  output logic                          C_NaN_o,
  output logic                          Invalid_o,
  output logic [PARM_RM-1:0]            Rounding_mode_o
);

  localparam int FW = PARM_EXP + PARM_MANT + 1;
  localparam int EW = PARM_EXP + 2;

  localparam logic signed [EW-1:0] BIAS_W      = EW'(PARM_BIAS);
  // Product sits PARM_MANT+4 positions left of the addend's reference point.
  localparam logic signed [EW-1:0] WINDOW_W    = EW'(PARM_MANT + 4);
  localparam logic signed [EW-1:0] SHIFT_MAX_W = EW'(PARM_SHIFT_MAX);

  typedef struct packed {
    logic                sign;
    logic [PARM_EXP-1:0] exp;   // effective exponent (1 for zero/denormal)
    logic [PARM_MANT:0]  mant;  // hidden bit included
    logic                zero;
    logic                inf;
    logic                nan;
    logic                snan;
  } op_t;

  function automatic op_t decode(input logic [FW-1:0] v);
    op_t                 o;
    logic [PARM_EXP-1:0] e;
    logic [PARM_MANT-1:0] m;
    o      = '0;
    e      = v[FW-2:PARM_MANT];
    m      = v[PARM_MANT-1:0];
    o.sign = v[FW-1];
    o.zero = (e == '0) && (m == '0);
    o.inf  = (e == '1) && (m == '0);
    o.nan  = (e == '1) && (m != '0);
    // Quiet bit is the mantissa MSB; a NaN with it clear is signalling.
    o.snan = o.nan && !m[PARM_MANT-1];
    o.exp  = (e == '0) ? PARM_EXP'(1) : e;
    o.mant = {(e != '0), m};
    return o;
  endfunction

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s2_valid;
  logic s2_advance;

  assign s2_advance = !s2_valid || Ready_i;
  assign Ready_o    = !s1_valid || s2_advance;
  assign Valid_o    = s2_valid;

  // ---------------- stage 1: decode ----------------
  op_t              dec_a;
  op_t              s1_a;
  op_t              s1_b;
  op_t              s1_c;
  logic [PARM_RM-1:0] s1_rm;

  always_comb begin
    dec_a      = decode(A_i);
    dec_a.sign = A_i[FW-1] ^ Sub_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_rm    <= '0;
    end else if (Ready_o) begin
      s1_valid <= Valid_i;
      if (Valid_i) begin
        s1_a  <= dec_a;
        s1_b  <= decode(B_i);
        s1_c  <= decode(C_i);
        s1_rm <= Rounding_mode_i;
      end
    end
  end

  // ---------------- stage 2: exponent / alignment / invalid ----------------
  logic signed [EW-1:0] ea_w;
  logic signed [EW-1:0] eb_w;
  logic signed [EW-1:0] ec_w;
  logic signed [EW-1:0] exp_bc_c;
  logic signed [EW-1:0] diff_c;
  logic signed [EW-1:0] exp_res_c;
  logic [6:0]           shift_c;
  logic                 a_dom_c;
  logic                 sub_sign_c;
  logic                 any_nan_c;
  logic                 invalid_c;

  assign ea_w     = signed'({2'b00, s1_a.exp});
  assign eb_w     = signed'({2'b00, s1_b.exp});
  assign ec_w     = signed'({2'b00, s1_c.exp});
  assign exp_bc_c = eb_w + ec_w - BIAS_W;
  assign diff_c   = exp_bc_c - ea_w + WINDOW_W;

  always_comb begin
    a_dom_c   = 1'b0;
    shift_c   = '0;
    exp_res_c = exp_bc_c + WINDOW_W;
    if (diff_c < 0) begin
      // Addend lies entirely above the product window: no shift, addend sets the exponent.
      a_dom_c   = 1'b1;
      exp_res_c = ea_w;
    end else if (diff_c > SHIFT_MAX_W) begin
      // Addend is far below the product; it only contributes sticky bits.
      shift_c = 7'(PARM_SHIFT_MAX);
    end else begin
      shift_c = diff_c[6:0];
    end
  end

  assign sub_sign_c = s1_a.sign ^ s1_b.sign ^ s1_c.sign;
  assign any_nan_c  = s1_a.nan | s1_b.nan | s1_c.nan;
  // Inf - Inf is only invalid when no NaN is present (a NaN would propagate instead).
  assign invalid_c  = (s1_a.snan | s1_b.snan | s1_c.snan)
                    | (s1_b.inf & s1_c.zero)
                    | (s1_c.inf & s1_b.zero)
                    | ((s1_b.inf | s1_c.inf) & s1_a.inf & sub_sign_c & !any_nan_c);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s2_valid        <= 1'b0;
      A_Sign_o        <= 1'b0;
      B_Sign_o        <= 1'b0;
      C_Sign_o        <= 1'b0;
      A_Exp_raw_o     <= '0;
      A_Mant_o        <= '0;
      B_Mant_o        <= '0;
      C_Mant_o        <= '0;
      Exp_bc_o        <= '0;
      Exp_o           <= '0;
      Align_shift_o   <= '0;
      A_dominant_o    <= 1'b0;
      Sub_Sign_o      <= 1'b0;
      A_DeN_o         <= 1'b0;
      A_Inf_o         <= 1'b0;
      B_Inf_o         <= 1'b0;
      C_Inf_o         <= 1'b0;
      A_Zero_o        <= 1'b0;
      B_Zero_o        <= 1'b0;
      C_Zero_o        <= 1'b0;
      A_NaN_o         <= 1'b0;
      B_NaN_o         <= 1'b0;
      C_NaN_o         <= 1'b0;
      Invalid_o       <= 1'b0;
      Rounding_mode_o <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        A_Sign_o        <= s1_a.sign;
        B_Sign_o        <= s1_b.sign;
        C_Sign_o        <= s1_c.sign;
        A_Exp_raw_o     <= s1_a.exp;
        A_Mant_o        <= s1_a.mant;
        B_Mant_o        <= s1_b.mant;
        C_Mant_o        <= s1_c.mant;
        Exp_bc_o        <= exp_bc_c;
        Exp_o           <= exp_res_c;
        Align_shift_o   <= shift_c;
        A_dominant_o    <= a_dom_c;
        Sub_Sign_o      <= sub_sign_c;
        // Hidden bit clear means exponent field 0; nonzero mantissa then means denormal.
        A_DeN_o         <= !s1_a.mant[PARM_MANT] && !s1_a.zero;
        A_Inf_o         <= s1_a.inf;
        B_Inf_o         <= s1_b.inf;
        C_Inf_o         <= s1_c.inf;
        A_Zero_o        <= s1_a.zero;
        B_Zero_o        <= s1_b.zero;
        C_Zero_o        <= s1_c.zero;
        A_NaN_o         <= s1_a.nan;
        B_NaN_o         <= s1_b.nan;
        C_NaN_o         <= s1_c.nan;
        Invalid_o       <= invalid_c;
        Rounding_mode_o <= s1_rm;
      end
    end
  end

endmodule

// File: tb/tb_fma_operand_unpack.sv
// tb_fma_operand_unpack: directed literal vectors, backpressure, mid-flight reset and random traffic
// checked against an arithmetic model of the unpack front-end, compared on every valid output cycle.
module tb_fma_operand_unpack;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        Valid_i;
  logic        Ready_o;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic [31:0] C_i;
  logic        Sub_i;
  logic [2:0]  Rounding_mode_i;
  logic        Valid_o;
  logic        Ready_i;
  logic        A_Sign_o, B_Sign_o, C_Sign_o;
  logic [7:0]  A_Exp_raw_o;
  logic [23:0] A_Mant_o, B_Mant_o, C_Mant_o;
  logic [9:0]  Exp_bc_o, Exp_o;
  logic [6:0]  Align_shift_o;
  logic        A_dominant_o, Sub_Sign_o, A_DeN_o;
  logic        A_Inf_o, B_Inf_o, C_Inf_o;
  logic        A_Zero_o, B_Zero_o, C_Zero_o;
  logic        A_NaN_o, B_NaN_o, C_NaN_o;
  logic        Invalid_o;
  logic [2:0]  Rounding_mode_o;

  always #5 clk = ~clk;

  fma_operand_unpack dut (
    .clk_i(clk), .rst_ni(rst_ni), .Valid_i(Valid_i), .Ready_o(Ready_o),
    .A_i(A_i), .B_i(B_i), .C_i(C_i), .Sub_i(Sub_i), .Rounding_mode_i(Rounding_mode_i),
    .Valid_o(Valid_o), .Ready_i(Ready_i),
    .A_Sign_o(A_Sign_o), .B_Sign_o(B_Sign_o), .C_Sign_o(C_Sign_o),
    .A_Exp_raw_o(A_Exp_raw_o), .A_Mant_o(A_Mant_o), .B_Mant_o(B_Mant_o), .C_Mant_o(C_Mant_o),
    .Exp_bc_o(Exp_bc_o), .Exp_o(Exp_o), .Align_shift_o(Align_shift_o),
    .A_dominant_o(A_dominant_o), .Sub_Sign_o(Sub_Sign_o), .A_DeN_o(A_DeN_o),
    .A_Inf_o(A_Inf_o), .B_Inf_o(B_Inf_o), .C_Inf_o(C_Inf_o),
    .A_Zero_o(A_Zero_o), .B_Zero_o(B_Zero_o), .C_Zero_o(C_Zero_o),
    .A_NaN_o(A_NaN_o), .B_NaN_o(B_NaN_o), .C_NaN_o(C_NaN_o),
    .Invalid_o(Invalid_o), .Rounding_mode_o(Rounding_mode_o)
  );

  typedef struct packed {
    logic        a_sign, b_sign, c_sign;
    logic [7:0]  a_exp;
    logic [23:0] a_mant, b_mant, c_mant;
    logic [9:0]  exp_bc, exp_o;
    logic [6:0]  shift;
    logic        a_dom, sub_sign, a_den;
    logic        a_inf, b_inf, c_inf, a_zero, b_zero, c_zero, a_nan, b_nan, c_nan;
    logic        invalid;
    logic [2:0]  rm;
  } res_t;

  res_t act;
  assign act = {A_Sign_o, B_Sign_o, C_Sign_o, A_Exp_raw_o, A_Mant_o, B_Mant_o, C_Mant_o,
                Exp_bc_o, Exp_o, Align_shift_o, A_dominant_o, Sub_Sign_o, A_DeN_o,
                A_Inf_o, B_Inf_o, C_Inf_o, A_Zero_o, B_Zero_o, C_Zero_o,
                A_NaN_o, B_NaN_o, C_NaN_o, Invalid_o, Rounding_mode_o};

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  bit   saw_ready_low = 1'b0;
  bit   drv_done = 1'b0;
  res_t exp_q[$];
  res_t dummy;

  logic [31:0] bnd_a     [4] = '{32'h28000000, 32'h27800000, 32'h4D000000, 32'h4D800000};
  int          bnd_shift [4] = '{74, 74, 0, 0};
  int          bnd_dom   [4] = '{0, 0, 0, 1};
  int          bnd_expo  [4] = '{154, 154, 154, 155};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // ---------------- reference model ----------------
  function automatic bit f_zero(input logic [31:0] x); return x[30:0] == 31'd0; endfunction
  function automatic bit f_inf (input logic [31:0] x); return x[30:0] == 31'h7F800000; endfunction
  function automatic bit f_nan (input logic [31:0] x); return x[30:23] == 8'hFF && x[22:0] != 0; endfunction
  function automatic bit f_snan(input logic [31:0] x); return f_nan(x) && !x[22]; endfunction
  function automatic int f_exp (input logic [31:0] x); return (x[30:23] == 0) ? 1 : int'(x[30:23]); endfunction

  function automatic res_t model(input logic [31:0] a, b, c, input logic sub, input logic [2:0] rm);
    res_t r;
    int   ea, ebc, diff, expo, sh;
    bit   anynan;
    r          = '0;
    ea         = f_exp(a);
    ebc        = f_exp(b) + f_exp(c) - 127;
    diff       = ebc - ea + 27;
    if (diff < 0) begin
      r.a_dom = 1'b1; sh = 0; expo = ea;
    end else begin
      sh   = (diff > 74) ? 74 : diff;
      expo = ebc + 27;
    end
    r.a_sign   = a[31] ^ sub;
    r.b_sign   = b[31];
    r.c_sign   = c[31];
    r.a_exp    = 8'(ea);
    r.a_mant   = {a[30:23] != 0, a[22:0]};
    r.b_mant   = {b[30:23] != 0, b[22:0]};
    r.c_mant   = {c[30:23] != 0, c[22:0]};
    r.exp_bc   = 10'(ebc);
    r.exp_o    = 10'(expo);
    r.shift    = 7'(sh);
    r.sub_sign = r.a_sign ^ r.b_sign ^ r.c_sign;
    r.a_den    = a[30:23] == 0 && a[22:0] != 0;
    r.a_inf = f_inf(a);  r.b_inf = f_inf(b);  r.c_inf = f_inf(c);
    r.a_zero = f_zero(a); r.b_zero = f_zero(b); r.c_zero = f_zero(c);
    r.a_nan = f_nan(a);  r.b_nan = f_nan(b);  r.c_nan = f_nan(c);
    anynan     = r.a_nan || r.b_nan || r.c_nan;
    r.invalid  = f_snan(a) || f_snan(b) || f_snan(c) || (r.b_inf && r.c_zero) || (r.c_inf && r.b_zero)
              || ((r.b_inf || r.c_inf) && r.a_inf && r.sub_sign && !anynan);
    r.rm       = rm;
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
    end else begin
      if (Valid_o) begin
        if (exp_q.size() == 0) check("unexpected_valid", 128'(1), 128'(0));
        else begin
          check("out_fields", 128'(act), 128'(exp_q[0]));
          if (Ready_i) begin dummy = exp_q.pop_front(); n_out++; end
        end
      end
      if (!Ready_o) saw_ready_low = 1'b1;
      if (Valid_i && Ready_o) exp_q.push_back(model(A_i, B_i, C_i, Sub_i, Rounding_mode_i));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 5))
      0: e = 8'h00;  1: e = 8'hFF;  2: e = 8'd1;  3: e = 8'hFE;
      default: e = 8'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0: m = 23'h0;  1: m = 23'h400000;  2: m = 23'h1;  3: m = 23'h7FFFFF;
      default: m = 23'($urandom);
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Called and returns at posedge+1.
  task automatic send_one(input logic [31:0] a, b, c, input logic sub, input logic [2:0] rm);
    bit accepted = 1'b0;
    A_i = a; B_i = b; C_i = c; Sub_i = sub; Rounding_mode_i = rm; Valid_i = 1'b1;
    for (int k = 0; k < 64 && !accepted; k++) begin
      @(negedge clk);
      accepted = Ready_o;
      @(posedge clk); #1;
    end
    Valid_i = 1'b0;
    if (!accepted) check("send_timeout", 128'(0), 128'(1));
  endtask

  // Leaves the bench at the negedge where Valid_o is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (Valid_o) return;
    end
    check("out_timeout", 128'(0), 128'(1));
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(posedge clk); k++; end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n0;
    rst_ni = 1'b0; Valid_i = 1'b0; Ready_i = 1'b0;
    A_i = '0; B_i = '0; C_i = '0; Sub_i = 1'b0; Rounding_mode_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 128'(Valid_o), 128'(0));
    check("rst_ready", 128'(Ready_o), 128'(1));
    check("rst_data",  128'(act),     128'(0));
    @(posedge clk); #1;
    rst_ni = 1'b1; Ready_i = 1'b1;

    // 1.0 + 2.0*3.0
    send_one(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 3'd2);
    wait_out(lat);
    check("t1_latency", 128'(lat), 128'(2));
    check("t1_exp_bc",  128'(Exp_bc_o), 128'(129));
    check("t1_shift",   128'(Align_shift_o), 128'(29));
    check("t1_exp_o",   128'(Exp_o), 128'(156));
    check("t1_dom_sub_inv", 128'({A_dominant_o, Sub_Sign_o, Invalid_o}), 128'(0));
    check("t1_rm",      128'(Rounding_mode_o), 128'(2));
    @(posedge clk); #1;

    // Inf * 0
    send_one(32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 3'd0);
    wait_out(lat);
    check("t2_binf_czero_inv", 128'({B_Inf_o, C_Zero_o, Invalid_o}), 128'(3'b111));
    @(posedge clk); #1;

    // sNaN addend
    send_one(32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b0, 3'd0);
    wait_out(lat);
    check("t3_snan_nan_inv", 128'({A_NaN_o, Invalid_o}), 128'(2'b11));
    @(posedge clk); #1;

    // qNaN addend
    send_one(32'h7FC00000, 32'h3F800000, 32'h3F800000, 1'b0, 3'd0);
    wait_out(lat);
    check("t4_qnan_nan_inv", 128'({A_NaN_o, Invalid_o}), 128'(2'b10));
    @(posedge clk); #1;

    // smallest denormal addend, shift clamps
    send_one(32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 3'd0);
    wait_out(lat);
    check("t5_den",      128'(A_DeN_o), 128'(1));
    check("t5_exp_raw",  128'(A_Exp_raw_o), 128'(1));
    check("t5_mant",     128'(A_Mant_o), 128'(24'h000001));
    check("t5_shift",    128'(Align_shift_o), 128'(74));
    @(posedge clk); #1;

    // Inf - Inf via fused subtract
    send_one(32'h7F800000, 32'h7F800000, 32'h3F800000, 1'b1, 3'd0);
    wait_out(lat);
    check("t6_sign_sub_inv", 128'({A_Sign_o, Sub_Sign_o, Invalid_o}), 128'(3'b111));
    @(posedge clk); #1;

    // alignment window boundaries with B = C = 1.0
    for (int i = 0; i < 4; i++) begin
      send_one(bnd_a[i], 32'h3F800000, 32'h3F800000, 1'b0, 3'd1);
      wait_out(lat);
      check("bnd_shift", 128'(Align_shift_o), 128'(bnd_shift[i]));
      check("bnd_dom",   128'(A_dominant_o),  128'(bnd_dom[i]));
      check("bnd_exp_o", 128'(Exp_o),         128'(bnd_expo[i]));
      @(posedge clk); #1;
    end

    // backpressure: 4 back-to-back triples, Ready_i low for 3 cycles
    n0 = n_out; saw_ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_one(rand_op(), rand_op(), rand_op(), 1'($urandom), 3'($urandom));
      end
      begin
        repeat (2) @(posedge clk); #1; Ready_i = 1'b0;
        repeat (3) @(posedge clk); #1; Ready_i = 1'b1;
      end
    join
    drain();
    check("bp_count",      128'(n_out - n0), 128'(4));
    check("bp_ready_fell", 128'(saw_ready_low), 128'(1));

    // reset one cycle after accepting a triple
    send_one(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 3'd3);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_valid", 128'(Valid_o), 128'(0));
    end
    check("midrst_ready", 128'(Ready_o), 128'(1));
    @(posedge clk); #1;

    // random traffic with random backpressure
    n0 = n_out; drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_one(rand_op(), rand_op(), rand_op(), 1'($urandom), 3'($urandom));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          Ready_i = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    Ready_i = 1'b1;
    drain();
    check("rand_count", 128'(n_out - n0), 128'(300));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
